// File: rtl/rx_frame_assembler.sv
// ---------------------------------------------------------------------------
// rx_frame_assembler
//
// Pops bytes from a show-ahead UART RX FIFO and assembles framed payloads of
// the form SYNC, B0, B1, B2, B3, C where C = B0 ^ B1 ^ B2 ^ B3. A good frame
// updates frame_data and pulses frame_valid. A checksum failure or an
// inter-byte timeout pulses frame_err and bumps a saturating error counter.
// A link timer drops link_up when no good frame has been seen for a while.
//
// Ports
//   pclk         in   1   clock, rising edge
//   rst          in   1   asynchronous reset, active low
//   rx_empty     in   1   FIFO empty flag; rx_data valid while low
//   rx_data      in   8   FIFO head byte
//   rd_uart      out  1   registered one-cycle pop strobe
//   frame_data   out  32  last good payload: [7:0] board ID, [31:8] points
//   frame_valid  out  1   pulse when frame_data is updated
//   frame_err    out  1   pulse on checksum failure or inter-byte timeout
//   err_cnt      out  8   saturating count of frame_err pulses
//   link_up      out  1   high while good frames keep arriving
// ---------------------------------------------------------------------------
module rx_frame_assembler #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         BYTE_TIMEOUT = 16,
  parameter int         LINK_TIMEOUT = 1024
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data,
  output logic        rd_uart,
  output logic [31:0] frame_data,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        link_up
);

  localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int LT_W = $clog2(LINK_TIMEOUT + 1);
  localparam logic [BT_W-1:0] BT_MAX = BT_W'(BYTE_TIMEOUT);
  localparam logic [LT_W-1:0] LT_MAX = LT_W'(LINK_TIMEOUT);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      xor_q, xor_d;
  logic [31:0]     payload_q, payload_d;
  logic            rd_uart_q, rd_uart_d;
  logic [31:0]     frame_data_q, frame_data_d;
  logic            frame_valid_q, frame_valid_d;
  logic            frame_err_q, frame_err_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            link_up_q, link_up_d;
  logic [BT_W-1:0] byte_tmr_q, byte_tmr_d;
  logic [LT_W-1:0] link_tmr_q, link_tmr_d;

  logic            accept;
  logic            timeout_hit;

  // The byte is captured in the same cycle the pop strobe is high; the FIFO
  // head only advances after that edge, so rx_data is still this byte.
  always_comb begin
    rd_uart_d = ~rx_empty & ~rd_uart_q;
    accept    = rd_uart_q;
  end

  // A byte accepted in the very cycle the timer hits its limit wins, so the
  // timeout is qualified with ~accept.
  always_comb begin
    timeout_hit = (state_q != HUNT) && !accept && (byte_tmr_q == BT_MAX);
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    xor_d         = xor_q;
    payload_d     = payload_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    byte_tmr_d    = byte_tmr_q;

    if (state_q == HUNT || accept) begin
      byte_tmr_d = '0;
    end else if (byte_tmr_q != BT_MAX) begin
      byte_tmr_d = byte_tmr_q + 1'b1;
    end

    if (timeout_hit) begin
      state_d     = HUNT;
      idx_d       = 2'd0;
      xor_d       = 8'h00;
      payload_d   = 32'h0;
      byte_tmr_d  = '0;
      frame_err_d = 1'b1;
    end else if (accept) begin
      case (state_q)
        HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            state_d   = PAYLOAD;
            idx_d     = 2'd0;
            xor_d     = 8'h00;
            payload_d = 32'h0;
          end
        end
        PAYLOAD: begin
          // SYNC_BYTE values here are ordinary payload; no resync.
          payload_d[{idx_q, 3'b000} +: 8] = rx_data;
          xor_d = xor_q ^ rx_data;
          if (idx_q == 2'd3) begin
            state_d = CHECK;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
        CHECK: begin
          if (rx_data == xor_q) begin
            frame_data_d  = payload_q;
            frame_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = HUNT;
          idx_d   = 2'd0;
          xor_d   = 8'h00;
        end
        default: begin
          state_d = HUNT;
          idx_d   = 2'd0;
          xor_d   = 8'h00;
        end
      endcase
    end
  end

  // Error counter sticks at all-ones; frame_err keeps pulsing regardless.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Link timer is restarted by the good-frame pulse so link_up rises in the
  // same cycle frame_valid is seen outside.
  always_comb begin
    link_tmr_d = link_tmr_q;
    link_up_d  = link_up_q;
    if (frame_valid_d) begin
      link_tmr_d = '0;
      link_up_d  = 1'b1;
    end else if (link_tmr_q != LT_MAX) begin
      link_tmr_d = link_tmr_q + 1'b1;
      if (link_tmr_d == LT_MAX) begin
        link_up_d = 1'b0;
      end
    end else begin
      link_up_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q       <= HUNT;
      idx_q         <= 2'd0;
      xor_q         <= 8'h00;
      payload_q     <= 32'h0;
      rd_uart_q     <= 1'b0;
      frame_data_q  <= 32'h0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      err_cnt_q     <= 8'h00;
      link_up_q     <= 1'b0;
      byte_tmr_q    <= '0;
      link_tmr_q    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      xor_q         <= xor_d;
      payload_q     <= payload_d;
      rd_uart_q     <= rd_uart_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      err_cnt_q     <= err_cnt_d;
      link_up_q     <= link_up_d;
      byte_tmr_q    <= byte_tmr_d;
      link_tmr_q    <= link_tmr_d;
    end
  end

  assign rd_uart     = rd_uart_q;
  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign err_cnt     = err_cnt_q;
  assign link_up     = link_up_q;

endmodule

// File: tb/tb_rx_frame_assembler.sv
module tb_rx_frame_assembler;

  logic        pclk;
  logic        rst;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        rd_uart;
  logic [31:0] frame_data;
  logic        frame_valid;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        link_up;

  int checks = 0;
  int errors = 0;
  int validCount = 0;
  int errCount = 0;
  int bothCount = 0;

  typedef struct {
    string       name;
    logic [63:0] bytes;
    int          n;
    logic [31:0] expData;
    int          expValid;
    int          expErr;
    logic [7:0]  expErrCnt;
    logic        expLink;
  } vec_t;

  vec_t vecs [6];

  rx_frame_assembler #(
    .SYNC_BYTE   (8'hA5),
    .BYTE_TIMEOUT(16),
    .LINK_TIMEOUT(1024)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .rx_empty   (rx_empty),
    .rx_data    (rx_data),
    .rd_uart    (rd_uart),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt),
    .link_up    (link_up)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (frame_valid) validCount <= validCount + 1;
    if (frame_err) errCount <= errCount + 1;
    if (frame_valid && frame_err) bothCount <= bothCount + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Models the show-ahead FIFO: presents one byte and pops it after the
  // edge at which the DUT's pop strobe is high.
  task automatic pushByte(input logic [7:0] b);
    bit done;
    done = 0;
    rx_data  = b;
    rx_empty = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge pclk);
      if (rd_uart) begin
        @(posedge pclk);
        #1;
        done = 1;
      end
    end
    rx_empty = 1'b1;
    if (!done) checkOutput("rd_uart_wait", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [63:0] bytes, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      pushByte(bytes[i*8 +: 8]);
      if (gap > 0 && i != n - 1) repeat (gap) @(posedge pclk);
    end
    repeat (3) @(posedge pclk);
    @(negedge pclk);
  endtask

  int v0, e0;

  initial begin
    vecs[0] = '{"good",        64'h0000_6001_2345_07A5, 6, 32'h01234507, 1, 0, 8'd0, 1'b1};
    vecs[1] = '{"bad_csum",    64'h0000_6101_2345_07A5, 6, 32'h01234507, 0, 1, 8'd1, 1'b1};
    vecs[2] = '{"garbage",     64'h0100_0000_01A5_FF00, 8, 32'h00000001, 1, 0, 8'd1, 1'b1};
    vecs[3] = '{"sync_in_pl",  64'h0000_A500_0000_A5A5, 6, 32'h000000A5, 1, 0, 8'd1, 1'b1};
    vecs[4] = '{"all_ff",      64'h0000_00FF_FFFF_FFA5, 6, 32'hFFFFFFFF, 1, 0, 8'd1, 1'b1};
    vecs[5] = '{"mixed",       64'h0000_0878_5634_12A5, 6, 32'h78563412, 1, 0, 8'd1, 1'b1};

    rst      = 1'b0;
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    checkOutput("rst_rd_uart", {31'd0, rd_uart}, 32'd0);
    checkOutput("rst_frame_data", frame_data, 32'h0);
    checkOutput("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("rst_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    checkOutput("rst_link_up", {31'd0, link_up}, 32'd0);
    rst = 1'b1;
    @(posedge pclk);
    #1;

    for (int i = 0; i < 6; i++) begin
      v0 = validCount;
      e0 = errCount;
      applyStimulus(vecs[i].bytes, vecs[i].n, 0);
      checkOutput({vecs[i].name, "_data"}, frame_data, vecs[i].expData);
      checkOutput({vecs[i].name, "_valid"}, validCount - v0, vecs[i].expValid);
      checkOutput({vecs[i].name, "_err"}, errCount - e0, vecs[i].expErr);
      checkOutput({vecs[i].name, "_err_cnt"}, {24'd0, err_cnt}, {24'd0, vecs[i].expErrCnt});
      checkOutput({vecs[i].name, "_link"}, {31'd0, link_up}, {31'd0, vecs[i].expLink});
    end

    // Inter-byte timeout after two bytes, then a good frame must be found.
    @(posedge pclk); #1;
    v0 = validCount;
    e0 = errCount;
    pushByte(8'hA5);
    pushByte(8'h07);
    repeat (20) @(posedge pclk);
    @(negedge pclk);
    checkOutput("timeout_err", errCount - e0, 32'd1);
    checkOutput("timeout_valid", validCount - v0, 32'd0);
    checkOutput("timeout_err_cnt", {24'd0, err_cnt}, 32'd2);
    checkOutput("timeout_data", frame_data, 32'h78563412);
    @(posedge pclk); #1;
    applyStimulus(vecs[0].bytes, 6, 0);
    checkOutput("after_to_data", frame_data, 32'h01234507);
    checkOutput("after_to_valid", validCount - v0, 32'd1);
    checkOutput("after_to_err", errCount - e0, 32'd1);

    // FIFO stalls shorter than the byte timeout must not abort the frame.
    @(posedge pclk); #1;
    v0 = validCount;
    e0 = errCount;
    applyStimulus(vecs[5].bytes, 6, 10);
    checkOutput("stall_data", frame_data, 32'h78563412);
    checkOutput("stall_valid", validCount - v0, 32'd1);
    checkOutput("stall_err", errCount - e0, 32'd0);

    // Link loss: no good frame for the link timeout window.
    repeat (990) @(posedge pclk);
    @(negedge pclk);
    checkOutput("link_still_up", {31'd0, link_up}, 32'd1);
    repeat (40) @(posedge pclk);
    @(negedge pclk);
    checkOutput("link_down", {31'd0, link_up}, 32'd0);
    checkOutput("link_down_data", frame_data, 32'h78563412);

    // Reset in the middle of a frame; the tail must be ignored.
    @(posedge pclk); #1;
    pushByte(8'hA5);
    pushByte(8'h07);
    pushByte(8'h45);
    rst = 1'b0;
    #2;
    checkOutput("midrst_data", frame_data, 32'h0);
    checkOutput("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
    checkOutput("midrst_link", {31'd0, link_up}, 32'd0);
    checkOutput("midrst_rd_uart", {31'd0, rd_uart}, 32'd0);
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b1;
    @(posedge pclk); #1;
    v0 = validCount;
    e0 = errCount;
    applyStimulus(64'h0000_0000_0060_0123, 3, 0);
    checkOutput("midrst_tail_valid", validCount - v0, 32'd0);
    checkOutput("midrst_tail_err", errCount - e0, 32'd0);

    // Error counter saturation with bad frames.
    @(posedge pclk); #1;
    e0 = errCount;
    for (int f = 0; f < 260; f++) begin
      applyStimulus(vecs[1].bytes, 6, 0);
      if (f == 249) checkOutput("sat_250", {24'd0, err_cnt}, 32'd250);
    end
    checkOutput("sat_err_cnt", {24'd0, err_cnt}, 32'h000000FF);
    checkOutput("sat_err_pulses", errCount - e0, 32'd260);
    checkOutput("sat_data", frame_data, 32'h0);

    checkOutput("valid_err_overlap", bothCount, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_assembler.md
RX_FRAME_ASSEMBLER -- requirements
Module: rx_frame_assembler

Interface
REQ-001 Parameter SYNC_BYTE, 8'hA5: frame start marker.
REQ-002 Parameter BYTE_TIMEOUT, 16: maximum idle cycles allowed between bytes within one frame.
REQ-003 Parameter LINK_TIMEOUT, 1024: maximum cycles allowed without a good frame before the link is declared down.
REQ-004 pclk  input  1: sole clock; all logic on rising edge.
REQ-005 rst  input  1: reset, asynchronous and active-low.
REQ-006 rx_empty  input  1: UART RX FIFO empty flag; rx_data is valid while low (show-ahead FIFO).
REQ-007 rx_data  input  8: head byte of the UART RX FIFO.
REQ-008 rd_uart  output  1: registered one-cycle pop strobe to the UART RX FIFO.
REQ-009 frame_data  output  32: last good payload; [7:0] board ID, [31:8] BCD points.
REQ-010 frame_valid  output  1: one-cycle pulse when frame_data is updated.
REQ-011 frame_err  output  1: one-cycle pulse on checksum failure or inter-byte timeout.
REQ-012 err_cnt  output  8: saturating count of frame_err pulses.
REQ-013 link_up  output  1: high while good frames arrive within LINK_TIMEOUT.

Function
REQ-014 Frame format, in wire order: SYNC_BYTE, then payload bytes B0..B3, then checksum C. C = B0 ^ B1 ^ B2 ^ B3.
REQ-015 Payload mapping: B0 goes to [7:0], B1 to [15:8], B2 to [23:16], B3 to [31:24].
REQ-016 Byte acceptance: rd_uart asserts for one cycle when rx_empty=0 and rd_uart was 0 in the previous cycle, which gives at most one byte per 2 cycles. rx_data is captured in the cycle rd_uart=1.
REQ-017 State machine states: HUNT, PAYLOAD, CHECK.
- HUNT: an accepted byte equal to SYNC_BYTE moves to PAYLOAD with byte index 0; any other byte is discarded silently.
- PAYLOAD: each accepted byte is stored at the current index. After index 3, move to CHECK. A byte equal to SYNC_BYTE inside PAYLOAD is treated as data; no resync.
- CHECK: the accepted byte is compared to the running XOR, then the machine returns to HUNT.
REQ-018 Checksum match: frame_data loads the assembled payload and frame_valid pulses, both in the cycle after C is accepted (latency 1).
REQ-019 Checksum mismatch: frame_data holds its previous value, frame_err pulses in the cycle after C is accepted, and err_cnt increments.
REQ-020 Inter-byte timer:
- clears on every accepted byte and in HUNT; counts otherwise.
- in PAYLOAD or CHECK, reaching BYTE_TIMEOUT forces HUNT, pulses frame_err, increments err_cnt, and discards the partial payload.
REQ-021 A byte accepted in the same cycle the timer reaches BYTE_TIMEOUT takes priority: the byte is processed and no timeout is raised.
REQ-022 err_cnt saturates at 8'hFF; further errors still pulse frame_err.
REQ-023 Link timer:
- clears and sets link_up=1 on each frame_valid.
- otherwise increments, saturating at LINK_TIMEOUT.
- at LINK_TIMEOUT, link_up clears; frame_data is retained.
REQ-024 frame_valid and frame_err never assert in the same cycle.
REQ-025 FIFO empty mid-frame (rx_empty=1) only stalls the machine; only the inter-byte timer aborts a frame.

Reset
REQ-026 While rst=0:
- state = HUNT; byte index and running XOR = 0.
- rd_uart=0, frame_data=32'h0, frame_valid=0, frame_err=0, err_cnt=0, link_up=0, both timers=0.
REQ-027 Asserting rst mid-frame discards the partial frame. The first byte after rst deasserts is treated as in HUNT.

Verification
REQ-028 Good frame: bytes A5,07,45,23,01,60 -> frame_data=32'h01234507, one frame_valid pulse, link_up=1, err_cnt=0.
REQ-029 Bad checksum: bytes A5,07,45,23,01,61 -> frame_err pulse, err_cnt=1, frame_data unchanged from before.
REQ-030 Garbage then frame: bytes 00,FF,A5,01,00,00,00,01 -> garbage dropped silently, frame_data=32'h00000001, frame_valid once.
REQ-031 Timeout: bytes A5,07, then rx_empty held 1 for 20 cycles -> frame_err exactly once, machine in HUNT. A following good frame is then accepted normally.
REQ-032 Link loss and saturation:
- good frame, then 1024 idle cycles -> link_up falls to 0 and frame_data is retained.
- 260 consecutive bad frames -> err_cnt=8'hFF.
REQ-033 Reset mid-frame: rst=0 after bytes A5,07,45 -> all outputs at reset values. Then bytes 23,01,60 -> no frame_valid, no frame_err.
